// File: rtl/apb_initiator_bridge_if.sv
// Request/response stream plus APB3 bus of the initiator bridge, bundled so the
// bridge and its environment connect through one port each.
interface apb_initiator_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // The bridge side: accepts requests, issues APB transfers, returns responses.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  // The environment side: command source, response sink and APB completer.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/apb_initiator_bridge.sv
// Single-outstanding APB3 initiator: one request in, one SETUP/ACCESS transfer
// out, one response back, with an optional PREADY wait timeout.
module apb_initiator_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  apb_initiator_bridge_if.master  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Timeout fires on the last permitted ACCESS cycle, i.e. when the counter
  // would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept, done_ok, done_to;

  logic [31:0] paddr_q, pwdata_q, rdata_q;
  logic        pwrite_q, err_q, timeout_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt == LIMIT) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !bus.PREADY && TIMEOUT_CYCLES != 0 && wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // APB address/data hold their last values outside a transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      paddr_q  <= bus.req_addr;
      pwdata_q <= bus.req_wdata;
      pwrite_q <= bus.req_write;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (done_ok) begin
      rdata_q   <= pwrite_q ? 32'h0 : bus.PRDATA;
      err_q     <= bus.PSLVERR;
      timeout_q <= 1'b0;
    end else if (done_to) begin
      rdata_q   <= TIMEOUT_RDATA;
      err_q     <= 1'b1;
      timeout_q <= 1'b1;
    end
  end

  // Handshake and APB strobes decode from state only, so reset drops them at
  // once and rsp_ready never reaches req_ready combinationally.
  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.PSEL        = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE     = (state == ACCESS);
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Self-checking bench for apb_initiator_bridge: directed vector table, random
// transfers against a transfer-level model, backpressure and mid-transfer reset.
module tb_apb_initiator_bridge;

  localparam int unsigned TO_CYCLES = 4;
  localparam logic [31:0] TO_RDATA  = 32'hDEADBEEF;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  apb_initiator_bridge_if bus ();

  apb_initiator_bridge #(
    .TIMEOUT_CYCLES (TO_CYCLES),
    .TIMEOUT_RDATA  (TO_RDATA)
  ) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // ACCESS cycles with PREADY low before PREADY rises
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_timeout;
    int          exp_cycles; // ACCESS cycles the transfer should last
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level expectation: a slave ready after `waits` stalls either
  // answers within the timeout window or the bridge gives up after TO_CYCLES.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (TO_CYCLES != 0 && v.waits >= int'(TO_CYCLES)) begin
      r.exp_rdata   = TO_RDATA;
      r.exp_err     = 1'b1;
      r.exp_timeout = 1'b1;
      r.exp_cycles  = int'(TO_CYCLES);
    end else begin
      r.exp_rdata   = v.write ? 32'h0 : v.prdata;
      r.exp_err     = v.slverr;
      r.exp_timeout = 1'b0;
      r.exp_cycles  = v.waits + 1;
    end
    return r;
  endfunction

  // Starts and ends at 1 time unit after a rising edge, bridge idle.
  task automatic run_xfer(input vec_t v, input int rsp_delay);
    int   acc;
    logic rdy;
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check("idle_psel", 32'(bus.PSEL), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge clk); #1;
    // Accepted: scramble request fields to prove they were registered.
    bus.req_valid = 1'b0;
    bus.req_write = ~v.write;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    check("setup_psel", 32'(bus.PSEL), 32'd1);
    check("setup_penable", 32'(bus.PENABLE), 32'd0);
    check("setup_req_ready", 32'(bus.req_ready), 32'd0);
    check("setup_busy", 32'(bus.busy), 32'd1);
    check("setup_paddr", bus.PADDR, v.addr);
    check("setup_pwrite", 32'(bus.PWRITE), 32'(v.write));
    check("setup_pwdata", bus.PWDATA, v.wdata);
    bus.PREADY  = 1'($urandom);
    bus.PSLVERR = 1'($urandom);
    @(posedge clk); #1;
    acc = 0;
    while (bus.PSEL === 1'b1 && acc < 64) begin
      check("access_penable", 32'(bus.PENABLE), 32'd1);
      check("access_paddr", bus.PADDR, v.addr);
      check("access_pwrite", 32'(bus.PWRITE), 32'(v.write));
      check("access_pwdata", bus.PWDATA, v.wdata);
      rdy         = (acc == v.waits);
      bus.PREADY  = rdy;
      bus.PRDATA  = rdy ? v.prdata : $urandom;
      bus.PSLVERR = rdy ? v.slverr : 1'($urandom);
      acc++;
      @(posedge clk); #1;
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    check("access_cycles", 32'(acc), 32'(v.exp_cycles));
    check("resp_valid", 32'(bus.rsp_valid), 32'd1);
    check("resp_penable", 32'(bus.PENABLE), 32'd0);
    check("resp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("resp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    check("resp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_timeout));
    check("resp_req_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < rsp_delay; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      @(posedge clk); #1;
      check("hold_psel", 32'(bus.PSEL), 32'd0);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_rdata", bus.rsp_rdata, v.exp_rdata);
      check("hold_err", 32'(bus.rsp_err), 32'(v.exp_err));
      check("hold_timeout", 32'(bus.rsp_timeout), 32'(v.exp_timeout));
      check("hold_paddr", bus.PADDR, v.addr);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_paddr_kept", bus.PADDR, v.addr);
  endtask

  vec_t vecs [6];
  vec_t rv;

  initial begin
    vecs[0] = '{write:1'b1, addr:32'h10, wdata:32'h5, waits:0, prdata:32'h0, slverr:1'b0,
                exp_rdata:32'h0, exp_err:1'b0, exp_timeout:1'b0, exp_cycles:1};
    vecs[1] = '{write:1'b0, addr:32'h4, wdata:32'h0, waits:3, prdata:32'hA5, slverr:1'b0,
                exp_rdata:32'hA5, exp_err:1'b0, exp_timeout:1'b0, exp_cycles:4};
    vecs[2] = '{write:1'b0, addr:32'h8, wdata:32'h0, waits:99, prdata:32'h0, slverr:1'b0,
                exp_rdata:32'hDEADBEEF, exp_err:1'b1, exp_timeout:1'b1, exp_cycles:4};
    vecs[3] = '{write:1'b1, addr:32'h20, wdata:32'h1234, waits:0, prdata:32'h0, slverr:1'b1,
                exp_rdata:32'h0, exp_err:1'b1, exp_timeout:1'b0, exp_cycles:1};
    vecs[4] = '{write:1'b0, addr:32'h30, wdata:32'h0, waits:1, prdata:32'h77, slverr:1'b1,
                exp_rdata:32'h77, exp_err:1'b1, exp_timeout:1'b0, exp_cycles:2};
    vecs[5] = '{write:1'b0, addr:32'h44, wdata:32'h0, waits:4, prdata:32'h99, slverr:1'b0,
                exp_rdata:32'hDEADBEEF, exp_err:1'b1, exp_timeout:1'b1, exp_cycles:4};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    #3;
    check("rst_psel", 32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_paddr", bus.PADDR, 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], (i == 3) ? 10 : 0);

    for (int i = 0; i < 40; i++) begin
      rv.write  = 1'($urandom);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.waits  = int'($urandom_range(0, 6));
      rv.prdata = $urandom;
      rv.slverr = ($urandom_range(0, 3) == 0);
      run_xfer(model(rv), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ACCESS: strobes drop at once, no response.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h5C;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_psel", 32'(bus.PSEL), 32'd0);
    check("midrst_penable", 32'(bus.PENABLE), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_paddr", bus.PADDR, 32'h0);
    @(posedge clk); #1;
    check("inrst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rv = '{write:1'b0, addr:32'h60, wdata:32'h0, waits:2, prdata:32'hC0FFEE, slverr:1'b0,
           exp_rdata:32'hC0FFEE, exp_err:1'b0, exp_timeout:1'b0, exp_cycles:3};
    run_xfer(rv, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
